// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, transmitter state encoding and the
// CPU-visible address map used by the decoder, receiver and transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

    localparam logic [31:0] UART_CTRL_ADDR    = 32'h8000_0000;
    localparam logic [31:0] UART_RX_DATA_ADDR = 32'h8000_0004;
    localparam logic [31:0] UART_TX_DATA_ADDR = 32'h8000_0008;
    localparam logic [31:0] UART_AUX_ADDR     = 32'h8000_000C;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous-write FIFO with first-word fall-through read data.
// Pushes when full and pops when empty are ignored.
module uart_tx_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [Width-1:0]        din,
    output logic [Width-1:0]        dout,
    output logic [$clog2(Depth):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CountW = PtrW + 1;

    logic [Width-1:0]  mem [Depth];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CountW-1:0] count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CountW'(Depth));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CountW'(1);
                2'b01:   count_q <= count_q - CountW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: buffers bytes from the CPU handshake and serialises each
// as an 8N1 frame, LSB first, with back-to-back frames when data is queued.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned ClockFreq = 50_000_000,
    parameter int unsigned BaudRate  = 115_200,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic [UART_DATA_W-1:0] DataIn,
    input  logic                   DataInValid,
    output logic                   DataInReady,
    output logic                   SOut,
    output logic                   TxBusy
);

    localparam int unsigned ClksPerBit = clks_per_bit(ClockFreq, BaudRate);
    localparam int unsigned ClkCntW    = $clog2(ClksPerBit);
    localparam int unsigned CountW     = $clog2(FifoDepth) + 1;
    localparam int unsigned BitCntW    = $clog2(UART_DATA_W);

    localparam logic [ClkCntW-1:0] ClkCntMax  = ClkCntW'(ClksPerBit - 1);
    localparam logic [BitCntW-1:0] LastBit    = BitCntW'(UART_DATA_W - 1);
    localparam logic [CountW-1:0]  CountFull  = CountW'(FifoDepth);

    tx_state_e              state_q, state_d;
    logic [ClkCntW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   sout_q, sout_d;
    logic                   ready_q;
    logic                   busy_q;

    logic                   push;
    logic                   pop;
    logic                   bit_done;
    logic [UART_DATA_W-1:0] fifo_dout;
    logic [CountW-1:0]      fifo_count;
    logic [CountW-1:0]      count_next;
    logic                   fifo_full;
    logic                   fifo_empty;

    uart_tx_fifo #(
        .Depth (FifoDepth),
        .Width (UART_DATA_W)
    ) u_fifo (
        .clk   (Clock),
        .rst_n (Reset_n),
        .push  (push),
        .pop   (pop),
        .din   (DataIn),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign push     = DataInValid && ready_q && !fifo_full;
    assign bit_done = (clk_cnt_q == ClkCntMax);

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CountW'(1);
        end else if (!push && pop) begin
            count_next = fifo_count - CountW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_dout;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    state_d   = StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + ClkCntW'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[UART_DATA_W-1:1]};
                    if (bit_cnt_q == LastBit) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + ClkCntW'(1);
                end
            end
            StStop: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_dout;
                        bit_cnt_d = '0;
                        state_d   = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + ClkCntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is derived from the next state so SOut comes straight from a flop.
    always_comb begin
        sout_d = 1'b1;
        unique case (state_d)
            StIdle:  sout_d = 1'b1;
            StStart: sout_d = 1'b0;
            StData:  sout_d = shift_d[0];
            StStop:  sout_d = 1'b1;
            default: sout_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sout_q    <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sout_q    <= sout_d;
            ready_q   <= (count_next != CountFull);
            busy_q    <= (state_d != StIdle) || (count_next != '0);
        end
    end

    assign DataInReady = ready_q;
    assign SOut        = sout_q;
    assign TxBusy      = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at 10 clocks per bit, depth-4 FIFO.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       sout;
    logic       tx_busy;

    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;

    logic [7:0] exp_q[$];
    int         start_log[$];

    typedef struct {
        logic [7:0] data;
        int         busy_edges;
    } byte_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic [2:0] exp_out;  // {SOut, TxBusy, DataInReady}
    } idle_vec_t;

    byte_vec_t  byte_tbl[5];
    idle_vec_t  idle_tbl[50];

    uart_transmitter #(
        .ClockFreq (1000),
        .BaudRate  (100),
        .FifoDepth (4)
    ) dut (
        .Clock       (clk),
        .Reset_n     (rst_n),
        .DataIn      (data_in),
        .DataInValid (data_valid),
        .DataInReady (data_ready),
        .SOut        (sout),
        .TxBusy      (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passes++;
        end
    endtask

    // Frame monitor: every cycle of a frame is compared against the expected byte.
    initial begin
        int         idx;
        int         err;
        logic       active;
        logic       exp_bit;
        logic [7:0] exp_byte;
        logic [7:0] got;
        active = 1'b0;
        idx = 0;
        err = 0;
        exp_byte = 8'h00;
        got = 8'h00;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                active = 1'b0;
            end else begin
                if (!active && sout === 1'b0) begin
                    active = 1'b1;
                    idx = 0;
                    err = 0;
                    got = 8'h00;
                    start_log.push_back(cyc);
                    check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    exp_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                end
                if (active) begin
                    if (idx < 10) exp_bit = 1'b0;
                    else if (idx < 90) exp_bit = exp_byte[(idx - 10) / 10];
                    else exp_bit = 1'b1;
                    if (sout !== exp_bit) err++;
                    if (idx >= 10 && idx < 90 && (idx % 10) == 5) got[(idx - 10) / 10] = sout;
                    if (idx == 99) begin
                        check("frame_byte", 32'(got), 32'(exp_byte));
                        check("frame_bit_errors", 32'(err), 32'd0);
                        active = 1'b0;
                    end
                    idx++;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, output int push_edge);
        data_in = d;
        data_valid = 1'b1;
        exp_q.push_back(d);
        @(negedge clk);
        data_valid = 1'b0;
        push_edge = cyc;
    endtask

    task automatic wait_idle(input int budget, output int edge_seen);
        int k;
        k = 0;
        while (tx_busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("busy_timeout", 32'(tx_busy === 1'b0), 32'd1);
        edge_seen = cyc;
    endtask

    task automatic idle_watch(input int n, input string name);
        int errs;
        errs = 0;
        repeat (n) begin
            @(negedge clk);
            if (sout !== 1'b1 || tx_busy !== 1'b0 || data_ready !== 1'b1) errs++;
        end
        check(name, 32'(errs), 32'd0);
    endtask

    task automatic reset_mid(input logic [7:0] d, input int offset, input logic pre_sout);
        int n;
        send_byte(d, n);
        while (cyc < n + offset) @(negedge clk);
        check("pre_reset_sout", 32'(sout), 32'(pre_sout));
        rst_n = 1'b0;
        #1;
        check("async_rst_sout", 32'(sout), 32'd1);
        check("async_rst_ready", 32'(data_ready), 32'd0);
        check("async_rst_busy", 32'(tx_busy), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_rst", 32'(data_ready), 32'd1);
        idle_watch(50, "idle_after_mid_rst");
    endtask

    initial begin
        int n;
        int e;
        int e1;

        byte_tbl[0] = '{data: 8'h55, busy_edges: 101};
        byte_tbl[1] = '{data: 8'h00, busy_edges: 101};
        byte_tbl[2] = '{data: 8'hFF, busy_edges: 101};
        byte_tbl[3] = '{data: 8'h80, busy_edges: 101};
        byte_tbl[4] = '{data: 8'h01, busy_edges: 101};
        for (int i = 0; i < 50; i++) begin
            idle_tbl[i] = '{data: 8'($urandom), valid: 1'b0, exp_out: 3'b101};
        end

        // Reset and release
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sout", 32'(sout), 32'd1);
        check("rst_ready", 32'(data_ready), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(data_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(data_ready), 32'd1);
        idle_watch(200, "idle_after_reset");

        // Single bytes
        for (int i = 0; i < 5; i++) begin
            start_log.delete();
            send_byte(byte_tbl[i].data, n);
            check("sout_high_at_push", 32'(sout), 32'd1);
            check("busy_at_push", 32'(tx_busy), 32'd1);
            @(negedge clk);
            check("start_fall", 32'(sout), 32'd0);
            wait_idle(300, e);
            check("busy_fall_edge", 32'(e - n), 32'(byte_tbl[i].busy_edges));
            check("single_frame_count", 32'(start_log.size()), 32'd1);
            if (start_log.size() > 0) check("start_latency", 32'(start_log[0] - n), 32'd1);
        end

        // Back-to-back
        start_log.delete();
        data_in = 8'hA5;
        data_valid = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        n = cyc;
        data_in = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        data_valid = 1'b0;
        wait_idle(400, e);
        check("b2b_frames", 32'(start_log.size()), 32'd2);
        if (start_log.size() == 2) check("b2b_gap", 32'(start_log[1] - start_log[0]), 32'd100);
        check("b2b_busy_fall", 32'(e - n), 32'd201);

        // Full FIFO
        start_log.delete();
        e1 = 0;
        for (int i = 1; i <= 6; i++) begin
            data_in = 8'(i);
            data_valid = 1'b1;
            if (i <= 5) exp_q.push_back(8'(i));
            @(negedge clk);
            if (i == 1) e1 = cyc;
            check("fill_ready", 32'(data_ready), (i >= 5) ? 32'd0 : 32'd1);
        end
        data_valid = 1'b0;
        while (cyc < e1 + 100) @(negedge clk);
        check("ready_full_before_pop", 32'(data_ready), 32'd0);
        @(negedge clk);
        check("ready_after_pop", 32'(data_ready), 32'd1);
        wait_idle(700, e);
        check("full_frames", 32'(start_log.size()), 32'd5);
        check("full_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame: during data bit 3 of 0xFF, then during a start bit
        reset_mid(8'hFF, 45, 1'b1);
        reset_mid(8'h00, 5, 1'b0);

        // Invalid data
        start_log.delete();
        for (int i = 0; i < 50; i++) begin
            data_in = idle_tbl[i].data;
            data_valid = idle_tbl[i].valid;
            @(negedge clk);
            check("invalid_data_idle", 32'({sout, tx_busy, data_ready}), 32'(idle_tbl[i].exp_out));
        end
        repeat (5) @(negedge clk);
        check("invalid_no_frames", 32'(start_log.size()), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
